// File: rtl/muldiv_unit_if.sv
// Execute-stage port bundle for the iterative multiply/divide unit.
// The master side (E stage / bench) drives requests; the slave side is the unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             mthi;
  logic             mtlo;
  logic             cancel;
  logic             mfsel;
  logic [WIDTH-1:0] HLOut;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             dz;

  modport master (
    output start, op, srcA, srcB, mthi, mtlo, cancel, mfsel,
    input  HLOut, hi, lo, busy, done, dz
  );

  modport slave (
    input  start, op, srcA, srcB, mthi, mtlo, cancel, mfsel,
    output HLOut, hi, lo, busy, done, dz
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide with HI/LO registers.
// Operands are reduced to magnitudes at launch, iterated WIDTH times, and the
// signs are re-applied in a single fix-up cycle before committing HI/LO.
module muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int CNTW  = $clog2(WIDTH+1)
) (
  input  logic           clk,
  input  logic           rst_n,
  muldiv_unit_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNTW-1:0]    count_q, count_d;
  // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // mult: multiplicand magnitude; div: divisor magnitude
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   srca_q, srca_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;     // result (product / quotient) negative
  logic               rneg_q, rneg_d;   // remainder negative (dividend sign)
  logic               divz_q, divz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  // launch-time operand conditioning; unsigned ops never sign-convert
  logic               sa, sb;
  logic [WIDTH-1:0]   maga, magb;
  assign sa   = ~bus.op[0] & bus.srcA[WIDTH-1];
  assign sb   = ~bus.op[0] & bus.srcB[WIDTH-1];
  assign maga = sa ? ('0 - bus.srcA) : bus.srcA;
  assign magb = sb ? ('0 - bus.srcB) : bus.srcB;

  // one shift-add step: add multiplicand when the multiplier LSB is set,
  // then shift the whole accumulator right (carry enters the top bit)
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};

  // one restoring-divide step: trial-subtract on the WIDTH+1 bit shifted
  // remainder; keep the difference and shift in a 1 when it does not borrow
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_step;
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
  assign div_step  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // sign fix-up values used in the FIX cycle
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  assign prod_fix = neg_q  ? ('0 - acc_q) : acc_q;
  assign quot_fix = neg_q  ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      srca_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      divz_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      srca_q   <= srca_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      divz_q   <= divz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  // next-state: launch / iterate / fix-up, with cancel overriding everything
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    srca_d   = srca_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    divz_d   = divz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = dz_q;

    if (bus.cancel) begin
      // abort: architectural state untouched, no done pulse
      state_d = S_IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            is_div_d = bus.op[1];
            acc_d    = {{WIDTH{1'b0}}, (bus.op[1] ? maga : magb)};
            opnd_d   = bus.op[1] ? magb : maga;
            neg_d    = sa ^ sb;
            rneg_d   = sa;
            divz_d   = bus.op[1] && (bus.srcB == '0);
            srca_d   = bus.srcA;
            count_d  = CNTW'(WIDTH);
            dz_d     = 1'b0;
            state_d  = S_CALC;
          end else begin
            if (bus.mthi) hi_d = bus.srcA;
            if (bus.mtlo) lo_d = bus.srcA;
          end
        end
        S_CALC: begin
          acc_d   = is_div_q ? div_step : mul_step;
          count_d = count_q - 1'b1;
          if (count_q == CNTW'(1)) state_d = S_FIX;
        end
        S_FIX: begin
          if (!is_div_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (divz_q) begin
            hi_d = srca_q;
            lo_d = '1;
            dz_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = done_q;
  assign bus.dz    = dz_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.HLOut = bus.mfsel ? hi_q : lo_q;

endmodule
